mixer_pipe: RTL and testbench
=============================

Name: mixer_pipe

Overview:
Pipelined, parametrised successor to the combinational interpolator/LO mixer in the delta-sigma modulator chain. Multiplies interpolated samples by the local-oscillator sample, applies optional negation and a parametrised power-of-two gain, and saturates the result to the output width. Sits between the interpolator and the modulator loop. Uses a valid/ready handshake on both sides and a sticky overflow flag.

Parameters:
DATA_W, 20, width of signed interpolated input sample
LO_W, 20, width of signed LO sample
OUT_W, 20, width of signed mixed output
SHIFT, 14, arithmetic right shift applied to the product (gain = 2^-SHIFT); legal range 1..DATA_W+LO_W-OUT_W
NEGATE, 1, 1 = negate the product before the shift (gain sign -1); 0 = no negation

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  interp_i/lo_i valid
in_ready  out  1  stage 1 can accept
interp_i  in  DATA_W  signed interpolated sample
lo_i  in  LO_W  signed LO sample
out_valid  out  1  mix_o valid
out_ready  in  1  downstream accepts
mix_o  out  OUT_W  signed mixed sample
sat_flag  out  1  sticky: a saturation has occurred
sat_clr  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (async, active-high): s1_valid, s2_valid, out_valid, sat_flag = 0; mix_o = 0; product register = 0. in_ready is combinational and reads 1 while rst is low after reset.
- Stage 1: on an in_valid & in_ready edge, register p = signed(interp_i) * signed(lo_i), full DATA_W+LO_W bits; s1_valid <= 1.
- Stage 2: on advance, compute q = NEGATE ? -p : p at DATA_W+LO_W+1 bits (no wrap, including -(min*min)); arithmetic shift right by SHIFT (floor); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register into mix_o; s2_valid <= 1.
- out_valid = s2_valid. Stage 2 is free when !s2_valid | out_ready. Stage 1 advances when s1_valid & stage 2 free. in_ready = !s1_valid | (stage 2 free). Full throughput is one sample per clock.
- Latency: 2 clocks from input handshake to out_valid when out_ready is held high.
- Backpressure: when out_ready is low and both stages are full, in_ready = 0 and mix_o/out_valid are held stable. No sample is dropped or duplicated.
- A stage 2 handshake with no stage 1 advance clears s2_valid.
- sat_flag: set on the clock in which a saturated value is loaded into mix_o. sat_clr clears it. If set and clear occur in the same cycle, set wins.
- A reset asserted mid-stream discards all in-flight samples immediately (async). There is no output pulse on reset release.
- mix_o holds its last value when out_valid = 0.

Optional Feature:
MIXER_ROUND_EN. When defined, stage 2 adds 2^(SHIFT-1) to q before the shift (round half up), with one guard bit so the add cannot overflow. When undefined, the shift truncates toward -inf. Saturation and the flag apply after rounding in both cases.

Decomposition:
- mixer_pkg: default widths, and a function sat_shift(q, shift, out_w) returning the saturated value and an overflow bit. A rounding-constant localparam is guarded by MIXER_ROUND_EN.
- One sub-module is natural: mixer_sat, a combinational shift/round/saturate block instantiated in stage 2. Multiplier inferred inline.

Test Plan:
- Defaults, interp=1000, lo=16384, out_ready=1 -> mix_o=-1000 exactly 2 clocks after handshake, sat_flag=0.
- interp=-524288, lo=-524288 -> q=-2^38, shifted -2^24 -> mix_o=-524288, sat_flag=1. Then sat_clr pulse -> sat_flag=0. Also interp=524287, lo=-524288 -> mix_o=524287, sat_flag=1.
- interp=3, lo=8192: without MIXER_ROUND_EN -> mix_o=-2; with MIXER_ROUND_EN -> mix_o=-1.
- Stream of 8 samples, out_ready low for cycles 3-6 -> in_ready drops after both stages fill, mix_o held stable, all 8 results emerge in order with no loss or duplication.
- Assert rst with 2 samples in flight -> out_valid, sat_flag, mix_o = 0 immediately. After release, the next input yields the correct result after 2 clocks.
- NEGATE=0, SHIFT=10, interp=-5, lo=1024 -> mix_o=-5. Same-cycle sat event and sat_clr -> sat_flag=1.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared widths, rounding selection and the shift/round/saturate helper for mixer_pipe.
// Optional build macro: MIXER_ROUND_EN (round half up before the shift instead of flooring).
package mixer_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_LO_W   = 20;
  localparam int DEF_OUT_W  = 20;
  localparam int DEF_SHIFT  = 14;

  // Working widths of the helper. The 96-bit intermediate leaves plenty of guard
  // bits above a 41-bit negated product, so the rounding add can never wrap.
  localparam int Q_MAX_W   = 96;
  localparam int OUT_MAX_W = 64;

`ifdef MIXER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef struct packed {
    logic                        ovf;
    logic signed [OUT_MAX_W-1:0] val;
  } sat_res_t;

  // Optionally add half an LSB, floor-shift right by 'shift', then clamp to a
  // signed out_w-bit range. ovf reports that the clamp was applied.
  function automatic sat_res_t sat_shift(input logic signed [Q_MAX_W-1:0] q,
                                         input int shift,
                                         input int out_w);
    sat_res_t                    res;
    logic signed [Q_MAX_W-1:0]   rnd;
    logic signed [Q_MAX_W-1:0]   r;
    logic signed [Q_MAX_W-1:0]   hi;
    logic signed [Q_MAX_W-1:0]   lo;
    rnd = '0;
    if (ROUND_EN) rnd = Q_MAX_W'(1) << (shift - 1);
    r  = (q + rnd) >>> shift;
    hi = (Q_MAX_W'(1) << (out_w - 1)) - Q_MAX_W'(1);
    lo = ~hi;
    res.ovf = 1'b0;
    res.val = r[OUT_MAX_W-1:0];
    if (r > hi) begin
      res.ovf = 1'b1;
      res.val = hi[OUT_MAX_W-1:0];
    end else if (r < lo) begin
      res.ovf = 1'b1;
      res.val = lo[OUT_MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mixer_sat.sv
// Combinational shift / optional round / saturate block used in stage 2 of mixer_pipe.
// Rounding behaviour follows MIXER_ROUND_EN through mixer_pkg.
module mixer_sat
  import mixer_pkg::*;
#(
  parameter int Q_W   = 41,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [Q_W-1:0]   q,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  sat_res_t res;
  logic     unused_hi;

  // Sign-extend into the helper's working width and evaluate shift/saturate.
  always_comb begin
    res = sat_shift({{(Q_MAX_W-Q_W){q[Q_W-1]}}, q}, SHIFT, OUT_W);
  end

  assign y         = res.val[OUT_W-1:0];
  assign ovf       = res.ovf;
  assign unused_hi = ^res.val[OUT_MAX_W-1:OUT_W];

endmodule

// File: rtl/mixer_pipe.sv
// Two-stage pipelined LO mixer: multiply, optional negate, power-of-two gain and
// saturation, with valid/ready on both sides and a sticky saturation flag.
// Optional build macro: MIXER_ROUND_EN (round half up instead of flooring).
module mixer_pipe
  import mixer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LO_W   = DEF_LO_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT,
  parameter bit NEGATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] interp_i,
  input  logic signed [LO_W-1:0]   lo_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  mix_o,
  output logic                     sat_flag,
  input  logic                     sat_clr
);

  localparam int P_W = DATA_W + LO_W;
  localparam int Q_W = P_W + 1;

  logic                  s1_valid;
  logic                  s2_valid;
  logic signed [P_W-1:0] p;
  logic signed [Q_W-1:0] p_ext;
  logic signed [Q_W-1:0] q;
  logic signed [OUT_W-1:0] sat_val;
  logic                  sat_ovf;
  logic                  s2_free;
  logic                  s1_adv;
  logic                  in_fire;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Stage 1: capture the full-width signed product on an input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p        <= '0;
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      p        <= P_W'(interp_i) * P_W'(lo_i);
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // One extra bit so negating min*min cannot wrap.
  always_comb begin
    p_ext = {p[P_W-1], p};
    q     = NEGATE ? -p_ext : p_ext;
  end

  mixer_sat #(
    .Q_W   (Q_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .q   (q),
    .y   (sat_val),
    .ovf (sat_ovf)
  );

  // Stage 2: load the saturated result when stage 1 advances; drain on a bare handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_o    <= '0;
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      mix_o    <= sat_val;
      s2_valid <= 1'b1;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Sticky saturation flag; a new saturation beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (s1_adv && sat_ovf) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mixer_pipe.sv
// Directed self-checking bench for mixer_pipe: default instance (NEGATE=1, SHIFT=14)
// plus a NEGATE=0, SHIFT=10 instance. Honors MIXER_ROUND_EN for the rounding case.
module tb_mixer_pipe;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic signed [19:0] interp_i;
  logic signed [19:0] lo_i;
  logic              out_valid;
  logic              out_ready;
  logic signed [19:0] mix_o;
  logic              sat_flag;
  logic              sat_clr;

  logic              b_in_valid;
  logic              b_in_ready;
  logic signed [19:0] b_interp;
  logic signed [19:0] b_lo;
  logic              b_out_valid;
  logic              b_out_ready;
  logic signed [19:0] b_mix_o;
  logic              b_sat_flag;
  logic              b_sat_clr;

  int tests;
  int fails;

  mixer_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .interp_i  (interp_i),
    .lo_i      (lo_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mix_o     (mix_o),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  mixer_pipe #(
    .NEGATE (1'b0),
    .SHIFT  (10)
  ) dut_pos (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .interp_i  (b_interp),
    .lo_i      (b_lo),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .mix_o     (b_mix_o),
    .sat_flag  (b_sat_flag),
    .sat_clr   (b_sat_clr)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic signed [19:0] a, input logic signed [19:0] b);
    in_valid = 1'b1;
    interp_i = a;
    lo_i     = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || mix_o !== 20'sd0 || sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: out_valid=%b mix_o=%0d sat_flag=%b, required 0/0/0", out_valid, mix_o, sat_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    push1(20'sd1000, 20'sd16384);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_latency_early: out_valid=%b, required 0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || mix_o !== -20'sd1000 || sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: out_valid=%b mix_o=%0d sat_flag=%b, required 1/-1000/0", out_valid, mix_o, sat_flag);
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || mix_o !== -20'sd1000) begin
      fails++;
      $display("[TB] FAIL basic_no_dup: out_valid=%b mix_o=%0d, required 0/-1000", out_valid, mix_o);
    end
  endtask

  task automatic test_saturation();
    push1(-20'sd524288, -20'sd524288);
    step();
    tests++;
    if (out_valid !== 1'b1 || mix_o !== 20'sh80000 || sat_flag !== 1'b1) begin
      fails++;
      $display("[TB] FAIL sat_negative: out_valid=%b mix_o=%0d sat_flag=%b, required 1/-524288/1", out_valid, mix_o, sat_flag);
    end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    tests++;
    if (sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sat_clear: sat_flag=%b, required 0", sat_flag);
    end
    push1(20'sd524287, -20'sd524288);
    step();
    tests++;
    if (out_valid !== 1'b1 || mix_o !== 20'sh7FFFF || sat_flag !== 1'b1) begin
      fails++;
      $display("[TB] FAIL sat_positive: out_valid=%b mix_o=%0d sat_flag=%b, required 1/524287/1", out_valid, mix_o, sat_flag);
    end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
  endtask

  task automatic test_rounding();
    logic signed [19:0] exp_v;
`ifdef MIXER_ROUND_EN
    exp_v = -20'sd1;
`else
    exp_v = -20'sd2;
`endif
    push1(20'sd3, 20'sd8192);
    step();
    tests++;
    if (out_valid !== 1'b1 || mix_o !== exp_v || sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rounding: out_valid=%b mix_o=%0d sat_flag=%b, required 1/%0d/0", out_valid, mix_o, sat_flag, exp_v);
    end
  endtask

  task automatic test_set_clr_same();
    in_valid = 1'b1;
    interp_i = 20'sd524287;
    lo_i     = -20'sd524288;
    sat_clr  = 1'b1;
    step();
    in_valid = 1'b0;
    tests++;
    if (sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL setclr_pre: sat_flag=%b, required 0", sat_flag);
    end
    step();
    sat_clr = 1'b0;
    tests++;
    if (sat_flag !== 1'b1 || mix_o !== 20'sh7FFFF) begin
      fails++;
      $display("[TB] FAIL setclr_same_cycle: sat_flag=%b mix_o=%0d, required 1/524287", sat_flag, mix_o);
    end
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int send;
    int recv;
    bit held_pending;
    bit saw_stall;
    logic signed [19:0] held_val;
    logic signed [19:0] exp_v;
    send = 0;
    recv = 0;
    held_pending = 1'b0;
    saw_stall = 1'b0;
    held_val = '0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (send < 8);
      interp_i  = 20'((send + 1) * 1000);
      lo_i      = 20'sd16384;
      @(negedge clk);
      if (held_pending) begin
        tests++;
        if (out_valid !== 1'b1 || mix_o !== held_val) begin
          fails++;
          $display("[TB] FAIL stream_hold: out_valid=%b mix_o=%0d, required 1/%0d", out_valid, mix_o, held_val);
        end
      end
      held_pending = out_valid && !out_ready;
      held_val = mix_o;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) send++;
      if (out_valid && out_ready) begin
        exp_v = 20'(-(recv + 1) * 1000);
        tests++;
        if (mix_o !== exp_v) begin
          fails++;
          $display("[TB] FAIL stream_data[%0d]: mix_o=%0d, required %0d", recv, mix_o, exp_v);
        end
        recv++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (recv != 8) begin
      fails++;
      $display("[TB] FAIL stream_count: received %0d, required 8 within cycle budget", recv);
    end
    tests++;
    if (saw_stall !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stream_stall: in_ready never dropped, required a stall");
    end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stream_extra: out_valid=%b after last sample, required 0", out_valid);
      end
    end
    step();
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1;
    interp_i = -20'sd524288;
    lo_i     = -20'sd524288;
    step();
    interp_i = 20'sd1000;
    lo_i     = 20'sd16384;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || sat_flag !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrst_pre: out_valid=%b sat_flag=%b, required 1/1", out_valid, sat_flag);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || sat_flag !== 1'b0 || mix_o !== 20'sd0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midrst_clear: out_valid=%b sat_flag=%b mix_o=%0d in_ready=%b, required 0/0/0/1", out_valid, sat_flag, mix_o, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrst_no_pulse: out_valid=%b, required 0", out_valid);
    end
    push1(20'sd1000, 20'sd16384);
    step();
    tests++;
    if (out_valid !== 1'b1 || mix_o !== -20'sd1000) begin
      fails++;
      $display("[TB] FAIL midrst_after: out_valid=%b mix_o=%0d, required 1/-1000", out_valid, mix_o);
    end
    step();
  endtask

  task automatic test_negate_off();
    b_in_valid = 1'b1;
    b_interp   = -20'sd5;
    b_lo       = 20'sd1024;
    step();
    b_in_valid = 1'b0;
    step();
    tests++;
    if (b_out_valid !== 1'b1 || b_mix_o !== -20'sd5 || b_sat_flag !== 1'b0) begin
      fails++;
      $display("[TB] FAIL negate_off: out_valid=%b mix_o=%0d sat_flag=%b, required 1/-5/0", b_out_valid, b_mix_o, b_sat_flag);
    end
    step();
  endtask

  // Sequence all scenarios and report.
  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    interp_i = '0;
    lo_i = '0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    b_in_valid = 1'b0;
    b_interp = '0;
    b_lo = '0;
    b_out_ready = 1'b1;
    b_sat_clr = 1'b0;

    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_set_clr_same();
    test_back_to_back();
    test_reset_midstream();
    test_negate_off();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
